// File: rtl/m_req_ack_pkg.sv
// Shared types and eligibility helpers for the req/ack arbiter.
package m_req_ack_pkg;

  localparam int WCNT_W = 8;
  localparam logic [WCNT_W-1:0] WCNT_MAX = '1;

  typedef enum logic [1:0] {
    ALL  = 2'b00,
    EVEN = 2'b01,
    ODD  = 2'b10,
    ALT  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  // ALT prefers the current parity but borrows the other one rather than stall.
  function automatic logic alt_select(input logic parity, input logic any_even,
                                      input logic any_odd);
    logic sel_odd;
    if (parity) sel_odd = !(!any_odd && any_even);
    else        sel_odd = !any_even && any_odd;
    return sel_odd;
  endfunction

  function automatic logic mode_allows(input mode_e mode, input logic alt_odd,
                                       input logic ch_odd);
    logic ok;
    case (mode)
      ALL:     ok = 1'b1;
      EVEN:    ok = !ch_odd;
      ODD:     ok = ch_odd;
      ALT:     ok = (ch_odd == alt_odd);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of vec at or above ptr, wrapping.
module rr_pick #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  int j;

  // Scan offsets high to low so the smallest offset from ptr is the last write.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (vec[j]) begin
        valid = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/m_req_ack_arb.sv
// Round-robin req/ack arbiter with mode-masked eligibility, fixed grant latency
// and per-channel starvation timeout.
//
// Handshake: a requester raises req[i] and holds it until ack[i] pulses for one
// cycle; dropping req[i] while granted abandons the grant with no ack.
module m_req_ack_arb
  import m_req_ack_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int LAT  = 2,
  parameter int TMO  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         req,
  input  logic [1:0]              mode,
  input  logic                    clr_err,
  output logic [N_CH-1:0]         ack,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] gnt_id,
  output logic                    tmo_err,
  output logic [$clog2(N_CH)-1:0] tmo_ch,
  output logic [1:0]              dbg_state
);

  localparam int W = $clog2(N_CH);
  localparam logic [3:0]        CNT_INIT = (LAT == 0) ? 4'd0 : 4'(LAT - 1);
  localparam logic [W-1:0]      LAST_CH  = W'(N_CH - 1);
  localparam logic [WCNT_W-1:0] TMO_M1   = WCNT_W'(TMO - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [W-1:0]    gnt_q, gnt_d;
  logic [W-1:0]    ptr_q, ptr_d;
  logic            par_q, par_d;
  logic [N_CH-1:0] ack_q, ack_d;
  logic            busy_q, busy_d;

  logic            any_even, any_odd, alt_odd;
  logic [N_CH-1:0] elig;
  logic            pick_valid;
  logic [W-1:0]    pick_idx;

  logic [WCNT_W-1:0] wcnt_q [N_CH];
  logic [N_CH-1:0]   hit;
  logic              hit_any;
  logic [W-1:0]      hit_idx;
  logic              tmo_err_q;
  logic [W-1:0]      tmo_ch_q;

  // Eligibility mask from the live mode; only consulted at the IDLE decision.
  always_comb begin
    any_even = 1'b0;
    any_odd  = 1'b0;
    elig     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (i[0]) any_odd  = any_odd  | req[i];
      else      any_even = any_even | req[i];
    end
    alt_odd = alt_select(par_q, any_even, any_odd);
    for (int i = 0; i < N_CH; i++) begin
      elig[i] = req[i] & mode_allows(mode_e'(mode), alt_odd, i[0]);
    end
  end

  rr_pick #(
    .N (N_CH),
    .W (W)
  ) u_pick (
    .vec   (elig),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    par_d   = par_q;
    ack_d   = '0;
    busy_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d  = pick_idx;
          cnt_d  = CNT_INIT;
          busy_d = 1'b1;
          if (LAT == 0) begin
            state_d         = ACK;
            ack_d[pick_idx] = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        busy_d = 1'b1;
        if (!req[gnt_q]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d      = ACK;
          ack_d[gnt_q] = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK: begin
        state_d = IDLE;
        ptr_d   = (gnt_q == LAST_CH) ? '0 : gnt_q + W'(1);
        // Parity follows the granted channel, which also covers the borrow case.
        par_d   = ~gnt_q[0];
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      par_q   <= 1'b0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      par_q   <= par_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  // A hit is the step from TMO-1 to TMO, so a saturated counter never re-fires.
  always_comb begin
    hit     = '0;
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      hit[i] = req[i] && !ack_q[i] && (wcnt_q[i] == TMO_M1);
    end
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) wcnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!req[i] || ack_q[i])          wcnt_q[i] <= '0;
        else if (wcnt_q[i] != WCNT_MAX)   wcnt_q[i] <= wcnt_q[i] + WCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_err_q <= 1'b0;
      tmo_ch_q  <= '0;
    end else if (hit_any && (!tmo_err_q || clr_err)) begin
      tmo_err_q <= 1'b1;
      tmo_ch_q  <= hit_idx;
    end else if (clr_err) begin
      tmo_err_q <= 1'b0;
      tmo_ch_q  <= '0;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_q;
  assign tmo_err   = tmo_err_q;
  assign tmo_ch    = tmo_ch_q;
  assign dbg_state = state_q;

endmodule
